// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues in-order instruction memory requests, buffers returned words
// with their PCs, and hands one instruction per cycle to decode. Redirect flushes and restarts.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stallD,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

  // Handshakes: a request transfers on a cycle with imem_req & imem_gnt; imem_req never
  // waits on imem_gnt. Decode consumes the head on a cycle with validD & ~stallD.

  logic [31:0]     pc;
  logic [31:0]     respPc;
  logic [31:0]     instrQ [DEPTH];
  logic [31:0]     pcQ    [DEPTH];
  logic [PtrW-1:0] rdPtr;
  logic [PtrW-1:0] wrPtr;
  logic [CntW-1:0] count;
  logic [CntW-1:0] inflight;
  logic [CntW-1:0] discard;
  logic [CntW-1:0] inflightNext;
  logic [CntW:0]   credits;
  logic            grant;
  logic            rspValid;
  logic            rspDrop;
  logic            push;
  logic            pop;

  always_comb begin
    // A request is only issued when both its queue slot and its response are accounted for.
    credits      = {1'b0, count} + {1'b0, inflight};
    imem_req     = credits < DepthC;
    imem_addr    = pc;
    grant        = imem_req & imem_gnt;
    rspValid     = imem_rvalid & (inflight != '0);
    rspDrop      = rspValid & (discard != '0);
    push         = rspValid & (discard == '0) & ~redirect;
    validD       = count != '0;
    pop          = validD & ~stallD & ~redirect;
    inflightNext = inflight + CntW'(grant) - CntW'(rspValid);
    instrD       = validD ? instrQ[rdPtr] : '0;
    pcD          = validD ? pcQ[rdPtr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      respPc   <= RESET_PC;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect) begin
      // Every request still outstanding after this cycle belongs to the old path.
      pc       <= redirect_pc;
      respPc   <= redirect_pc;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      inflight <= inflightNext;
      discard  <= inflightNext;
    end else begin
      if (grant) pc <= pc + 32'd4;
      inflight <= inflightNext;
      if (rspDrop) discard <= discard - 1'b1;
      if (push) begin
        respPc <= respPc + 32'd4;
        wrPtr  <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instrQ[wrPtr] <= imem_rdata;
      pcQ[wrPtr]    <= respPc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized memory/decode environment with an epoch-based
// reference model feeding an expected queue that a negedge monitor drains.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stallD;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] pcD;

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stallD(stallD),
    .validD(validD), .instrD(instrD), .pcD(pcD)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          readyCyc;
  } req_t;

  req_t        reqs[$];      // granted requests not yet answered by the memory
  logic [63:0] exp_q[$];     // {instr, pc} expected at decode, in order
  int          epoch;
  int          cyc;
  logic [31:0] expPc;
  bit          prevRedir;
  logic [31:0] prevRedirPc;
  int          nChecks;
  int          nFails;

  // knobs
  int          gntPct, stallPct, redirPct, latMin, latMax;
  bit          dataPlus, staleRvalid, forceRedir;
  logic [31:0] forcePc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    reqs.delete();
    exp_q.delete();
    epoch++;
    expPc     = RESET_PC;
    prevRedir = 1'b0;
  endtask

  task automatic idle_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    stallD      = 1'b0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle();
    bit          doRedir, doGnt, doStall, expReq, doResp;
    logic [31:0] rpc;
    req_t        rec;
    @(posedge clk);
    #1;
    cyc++;
    if (prevRedir) begin
      exp_q.delete();
      check("redir_addr", imem_addr, prevRedirPc);
      check("redir_valid", 32'(validD), 32'd0);
      prevRedir = 1'b0;
    end
    expReq = (exp_q.size() + reqs.size()) < DEPTH;
    check("imem_req", 32'(imem_req), 32'(expReq));
    check("imem_addr", imem_addr, expPc);

    doRedir = forceRedir || ($urandom_range(0, 99) < redirPct);
    rpc     = forceRedir ? forcePc : ($urandom & 32'hFFFF_FFFC);
    doGnt   = $urandom_range(0, 99) < gntPct;
    doStall = $urandom_range(0, 99) < stallPct;

    doResp = 1'b0;
    imem_rdata = $urandom;
    if (staleRvalid) begin
      doResp = 1'b1;
    end else if (reqs.size() > 0 && reqs[0].readyCyc <= cyc) begin
      doResp = 1'b1;
      rec = reqs.pop_front();
      imem_rdata = rec.data;
      if (rec.epoch == epoch && !doRedir) exp_q.push_back({rec.data, rec.addr});
    end

    if (expReq && doGnt) begin
      rec.addr     = expPc;
      rec.data     = dataPlus ? expPc + 32'h1000 : $urandom;
      rec.epoch    = epoch;
      rec.readyCyc = cyc + int'($urandom_range(latMin, latMax));
      reqs.push_back(rec);
      expPc = expPc + 32'd4;
    end

    if (doRedir) begin
      epoch++;
      expPc       = rpc;
      prevRedir   = 1'b1;
      prevRedirPc = rpc;
    end

    imem_gnt    = doGnt;
    imem_rvalid = doResp;
    redirect    = doRedir;
    redirect_pc = rpc;
    stallD      = doStall;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_valid", 32'(validD), 32'd0);
    check("rst_instr", instrD, 32'd0);
    check("rst_pc", pcD, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [63:0] monExp;
  always @(negedge clk) begin
    if (reset && validD && !stallD) begin
      if (exp_q.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_instr: pcD %h instrD %h, none expected (cycle %0d)", pcD, instrD, cyc);
      end else begin
        monExp = exp_q.pop_front();
        check("pcD", pcD, monExp[31:0]);
        check("instrD", instrD, monExp[63:32]);
      end
    end else if (reset && !validD) begin
      check("idle_pcD", pcD, 32'd0);
      check("idle_instrD", instrD, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    nChecks = 0; nFails = 0; cyc = 0; epoch = 0;
    gntPct = 100; stallPct = 0; redirPct = 0; latMin = 1; latMax = 1;
    dataPlus = 1'b1; staleRvalid = 1'b0; forceRedir = 1'b0; forcePc = '0;
    reset = 1'b0;
    idle_inputs();

    // streaming at latency 1, then a redirect coinciding with grant, response and pop
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      drive_cycle();
      if (k >= 3) check("stream_valid", 32'(validD), 32'd1);
    end
    forceRedir = 1'b1; forcePc = 32'h800;
    drive_cycle();
    forceRedir = 1'b0;
    repeat (10) drive_cycle();

    // backpressure: decode stalled until the credits run out, then released
    do_reset();
    stallPct = 100;
    repeat (6) drive_cycle();
    check("bp_req_low", 32'(imem_req), 32'd0);
    check("bp_head_pc", pcD, 32'h0);
    stallPct = 0;
    repeat (10) drive_cycle();

    // redirect with two requests in flight at latency 3
    do_reset();
    latMin = 3; latMax = 3;
    drive_cycle();
    drive_cycle();
    gntPct = 0; forceRedir = 1'b1; forcePc = 32'h400;
    drive_cycle();
    forceRedir = 1'b0; gntPct = 100;
    repeat (20) drive_cycle();

    // asynchronous reset with queued and in-flight words, then stale responses
    do_reset();
    latMin = 2; latMax = 2; stallPct = 100;
    repeat (4) drive_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("areset_valid", 32'(validD), 32'd0);
    check("areset_addr", imem_addr, RESET_PC);
    check("areset_req", 32'(imem_req), 32'd1);
    clear_model();
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    gntPct = 0; stallPct = 0; staleRvalid = 1'b1;
    repeat (3) begin
      drive_cycle();
      check("stale_valid", 32'(validD), 32'd0);
    end
    staleRvalid = 1'b0;
    repeat (2) begin
      drive_cycle();
      check("stale_valid", 32'(validD), 32'd0);
    end

    // randomized traffic
    do_reset();
    dataPlus = 1'b0;
    for (int p = 0; p < 6; p++) begin
      gntPct   = int'($urandom_range(30, 100));
      stallPct = int'($urandom_range(0, 60));
      redirPct = int'($urandom_range(0, 8));
      latMin   = 1;
      latMax   = int'($urandom_range(1, 6));
      repeat (500) drive_cycle();
    end
    gntPct = 0; stallPct = 0; redirPct = 0;
    repeat (30) drive_cycle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
